// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// -----------------
// Shares one backing-memory port among NUM_REQ region caches (write-through
// stores, write-back evictions, line refills). Round-robin arbitration, one
// outstanding memory transaction at a time, one-cycle completion pulse.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/_write  per-requester request valid and type (1 = write)
//   req_addr/_wdata   packed payloads, requester i at [i*W +: W]
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   resp_valid        one-hot completion pulse to the owning requester
//   resp_rdata        last read data, shared by all requesters
//   resp_err          qualifies resp_valid, high = memory timeout
//   mem_*             single external memory request/response port
//   busy              high whenever the arbiter is not IDLE
//   grant_id          current or last owner index
//
// Optional feature macro: CACHE_ARB_TIMEOUT_EN
//   Defined   : WAIT is bounded by TIMEOUT_CYCLES, expiry answers with resp_err.
//   Undefined : WAIT waits indefinitely, resp_err is tied low.
module cache_mem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  // Reject configurations the round-robin search and watchdog cannot handle.
  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : gBadParams
    $error("cache_mem_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  last_q;
  logic [IDX_W-1:0]  owner_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W-1:0] addrArr  [NUM_REQ];
  logic [DATA_W-1:0] wdataArr [NUM_REQ];
  logic              anyReq;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  candIdx;
  logic              timeoutHit;

  // Unpack the flat payload buses so the winner can select with a narrow index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addrArr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdataArr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: start one past the last owner and take the first
  // active request, wrapping around; the last owner is checked last.
  always_comb begin
    anyReq  = 1'b0;
    winner  = '0;
    candIdx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candIdx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!anyReq && req_valid[candIdx]) begin
        anyReq = 1'b1;
        winner = candIdx;
      end
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // The counter is zero on entry to WAIT and counts WAIT cycles; expiry on the
  // TIMEOUT_CYCLES-th WAIT cycle lands RESP exactly TIMEOUT_CYCLES after entry.
  always_comb begin
    cnt_d = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
  end

  assign timeoutHit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A real response on the expiry cycle wins, so the error flag stays low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_WAIT) begin
        err_q <= timeoutHit && !mem_resp_valid;
      end
    end
  end

  assign resp_err = (state_q == S_RESP) && err_q;
`else
  assign timeoutHit = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_resp_valid outside WAIT is simply never looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (anyReq) state_d = S_ISSUE;
      S_ISSUE: if (mem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (mem_resp_valid || timeoutHit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction capture at grant time and read-data capture in WAIT.
  // Writes leave resp_rdata untouched so it always holds the last read.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && anyReq) begin
        write_q <= req_write[winner];
        addr_q  <= addrArr[winner];
        wdata_q <= wdataArr[winner];
        owner_q <= winner;
        last_q  <= winner;
      end
      if (state_q == S_WAIT && mem_resp_valid && !write_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    req_ready     = '0;
    resp_valid    = '0;
    mem_req_valid = 1'b0;
    busy          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (anyReq) req_ready[winner] = 1'b1;
      S_ISSUE: mem_req_valid = 1'b1;
      S_RESP:  resp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign mem_write  = write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign grant_id   = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// --------------------
// Table-driven bench for cache_mem_arbiter (default build, no timeout
// watchdog). Each vector runs one full transaction; expected completions go
// into a scoreboard queue when the request is driven and are popped by a
// monitor when resp_valid fires.
module tb_cache_mem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_resp_valid;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;
  logic [1:0]                grant_id;

  cache_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // preSeq: 0 = none, 1 = plain reset, 2 = reset while in WAIT then stray response
  typedef struct {
    int          preSeq;
    logic [3:0]  valid;
    logic [3:0]  midValid;
    logic [3:0]  postValid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    int          readyDelay;
    int          respDelay;
    int          expGrant;
  } vec_t;

  typedef struct {
    int          grant;
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t        vecs [8];
  exp_t        sb [$];
  logic [31:0] expRdata;
  logic        monitorOn = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset the DUT and check every output returns to its idle value.
  task automatic resetDut();
    reset          = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    monitorOn = 1'b1;
    expRdata  = '0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req_valid", mem_req_valid, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_rdata", resp_rdata, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_req_ready", req_ready, 0);
  endtask

  // Reach WAIT for requester 0, reset there, then pulse a stray response.
  task automatic midWaitReset();
    req_valid = 4'b0001;
    req_write[0] = 1'b0;
    req_addr[31:0] = 32'h0000_0080;
    @(negedge clk);
    req_valid     = '0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    checkOutput("mrst_in_wait_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    expRdata = '0;
    #1;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_mem_req_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("mrst_stray_resp_valid", resp_valid, 0);
    checkOutput("mrst_stray_busy", busy, 0);
    @(negedge clk);
    #1;
    checkOutput("mrst_stray_resp_valid2", resp_valid, 0);
    checkOutput("mrst_stray_rdata", resp_rdata, 0);
  endtask

  // One full transaction, checked cycle by cycle from accept to RESP.
  task automatic applyStimulus(input vec_t v);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << v.expGrant;
    req_addr[v.expGrant*32 +: 32]  = v.addr;
    req_wdata[v.expGrant*32 +: 32] = v.wdata;
    req_write[v.expGrant]          = v.wr;
    req_valid                      = v.valid;
    #1;
    checkOutput("accept_req_ready", req_ready, oneHot);
    checkOutput("accept_busy", busy, 0);
    if (!v.wr) expRdata = v.memData;
    sb.push_back('{grant: v.expGrant, data: expRdata, err: 1'b0});
    @(negedge clk);
    req_valid = v.midValid;
    for (int i = 0; i <= v.readyDelay; i++) begin
      mem_req_ready = (i == v.readyDelay);
      #1;
      checkOutput("issue_mem_req_valid", mem_req_valid, 1);
      checkOutput("issue_mem_addr", mem_addr, v.addr);
      checkOutput("issue_mem_wdata", mem_wdata, v.wdata);
      checkOutput("issue_mem_write", mem_write, v.wr);
      checkOutput("issue_grant_id", grant_id, v.expGrant);
      checkOutput("issue_req_ready", req_ready, 0);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i <= v.respDelay; i++) begin
      mem_resp_valid = (i == v.respDelay);
      mem_rdata      = (i != v.respDelay) ? 32'hBAD0_0000 : (v.wr ? 32'hDEAD_BEEF : v.memData);
      #1;
      checkOutput("wait_mem_req_valid", mem_req_valid, 0);
      checkOutput("wait_busy", busy, 1);
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    req_valid      = v.postValid;
    #1;
    checkOutput("resp_latency", resp_valid, oneHot);
    checkOutput("resp_req_ready", req_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("resp_one_cycle", resp_valid, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("grant_id_hold", grant_id, v.expGrant);
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (monitorOn) begin
      #2;
      if (resp_valid !== '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got resp_valid %b expected none at %0t", resp_valid, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_owner", resp_valid, 32'(4'b0001 << e.grant));
          checkOutput("sb_rdata", resp_rdata, e.data);
          checkOutput("sb_err", resp_err, e.err);
        end
      end
    end
  end

  // Absolute time bound so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish by %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    expRdata       = '0;

    //          pre valid    mid      post     wr    addr           wdata          memData        rdy resp grant
    vecs[0] = '{1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_0001, 0, 0, 0};
    vecs[1] = '{1, 4'b1111, 4'b1111, 4'b1111, 1'b0, 32'h1000_0000, 32'h0000_0000, 32'hA000_0000, 0, 1, 0};
    vecs[2] = '{0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 32'h1000_0104, 32'h0000_0000, 32'hA111_1111, 1, 0, 1};
    vecs[3] = '{0, 4'b1111, 4'b1111, 4'b1111, 1'b1, 32'h1000_0208, 32'h5555_AAAA, 32'h0000_0000, 0, 2, 2};
    vecs[4] = '{0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 32'h1000_030C, 32'h0000_0000, 32'hA333_3333, 2, 0, 3};
    vecs[5] = '{0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 32'h2000_0010, 32'h1234_5678, 32'h0000_0000, 3, 1, 2};
    vecs[6] = '{2, 4'b1111, 4'b0000, 4'b0000, 1'b0, 32'h3000_0000, 32'h0000_0000, 32'h0BAD_F00D, 0, 0, 0};
    vecs[7] = '{0, 4'b0001, 4'b0010, 4'b0000, 1'b0, 32'h4000_0044, 32'h0000_0000, 32'h7777_0001, 1, 1, 0};

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].preSeq == 1) resetDut();
      else if (vecs[i].preSeq == 2) midWaitReset();
      applyStimulus(vecs[i]);
    end

    // Requester 1 withdrew during the last transaction: nothing may follow.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("withdraw_mem_req_valid", mem_req_valid, 0);
      checkOutput("withdraw_busy", busy, 0);
      checkOutput("withdraw_req_ready", req_ready, 0);
    end

    @(negedge clk);
    #3;
    checkOutput("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
